seq_control_unit: RTL and testbench

SEQ_CONTROL_UNIT -- requirements
Module: seq_control_unit

---
 rtl/seq_control_unit.sv | 171 +++++++++++++++++
 tb/tb_seq_control_unit.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_control_unit.sv
// Sequencer for a small CPU: FETCH/DECODE/EXEC/MEM/HALT control FSM with a
// call/return stack. Handshake: an opcode transfers on a cycle where instr_valid && instr_ready.
module seq_control_unit #(
   parameter  int OPW    = 6,
   parameter  int FLAGW  = 4,
   parameter  int AW     = 10,
   parameter  int SDEPTH = 4,
   localparam int SPW    = $clog2(SDEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [OPW-1:0]   opcode,
   input  logic [FLAGW-1:0] flags,
   input  logic [AW-1:0]    pc_in,
   input  logic             mem_ack,
   output logic             immediate,
   output logic             alu_op,
   output logic             bra,
   output logic             ret_sel,
   output logic             RD,
   output logic             WR,
   output logic             halted,
   output logic             err,
   output logic [AW-1:0]    ret_addr,
   output logic [SPW-1:0]   sp,
   output logic [2:0]       dbg_state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [OPW-1:0]   op_q, op_d;
   logic [SPW-1:0]   sp_q, sp_d;
   logic             err_q, err_d;
   logic             push;
   logic [AW-1:0]    stack_q [SDEPTH];

   // Opcode classification of the latched opcode; bits above 5 must be zero.
   logic [5:0] op6;
   logic       hi_zero;
   logic       is_nop, is_alu_reg, is_alu_imm, is_load, is_store;
   logic       is_bra, is_brz, is_brn, is_brc, is_bro, is_jmp, is_ret, is_hlt;
   logic       is_illegal;

   assign op6        = op_q[5:0];
   assign hi_zero    = ((op_q >> 6) == '0);
   assign is_nop     = hi_zero && (op6 == 6'h00);
   assign is_alu_reg = hi_zero && (op6[5:4] == 2'b00) && (op6 != 6'h00);
   assign is_alu_imm = hi_zero && (op6[5:4] == 2'b01);
   assign is_load    = hi_zero && (op6 == 6'h20);
   assign is_store   = hi_zero && (op6 == 6'h21);
   assign is_bra     = hi_zero && (op6 == 6'h30);
   assign is_brz     = hi_zero && (op6 == 6'h31);
   assign is_brn     = hi_zero && (op6 == 6'h32);
   assign is_brc     = hi_zero && (op6 == 6'h33);
   assign is_bro     = hi_zero && (op6 == 6'h34);
   assign is_jmp     = hi_zero && (op6 == 6'h35);
   assign is_ret     = hi_zero && (op6 == 6'h36);
   assign is_hlt     = hi_zero && (op6 == 6'h3F);
   assign is_illegal = !(is_nop || is_alu_reg || is_alu_imm || is_load || is_store ||
                         is_bra || is_brz || is_brn || is_brc || is_bro ||
                         is_jmp || is_ret || is_hlt);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         op_q    <= '0;
         sp_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         sp_q    <= sp_d;
         err_q   <= err_d;
      end
   end

   // Stack storage is deliberately left out of reset; sp alone defines validity.
   always_ff @(posedge clk) begin
      for (int i = 0; i < SDEPTH; i++) begin
         if (push && (sp_q == SPW'(i))) stack_q[i] <= pc_in;
      end
   end

   always_comb begin
      ret_addr = '0;
      for (int i = 0; i < SDEPTH; i++) begin
         if (sp_q == SPW'(i + 1)) ret_addr = stack_q[i];
      end
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      sp_d        = sp_q;
      err_d       = err_q;
      push        = 1'b0;
      instr_ready = 1'b0;
      immediate   = 1'b0;
      alu_op      = 1'b0;
      bra         = 1'b0;
      ret_sel     = 1'b0;
      RD          = 1'b0;
      WR          = 1'b0;
      halted      = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               op_d    = opcode;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            immediate = is_alu_imm;
            state_d   = S_EXEC;
         end
         S_EXEC: begin
            immediate = is_alu_imm;
            alu_op    = is_alu_reg || is_alu_imm;
            state_d   = S_FETCH;
            if (is_load || is_store) state_d = S_MEM;
            if (is_hlt)              state_d = S_HALT;
            if (is_bra || (is_brz && flags[3]) || (is_brn && flags[2]) ||
                (is_brc && flags[1]) || (is_bro && flags[0])) bra = 1'b1;
            // Overflowing call or empty return is dropped and flagged.
            if (is_jmp) begin
               if (sp_q != SPW'(SDEPTH)) begin
                  push = 1'b1;
                  sp_d = sp_q + SPW'(1);
                  bra  = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
            if (is_ret) begin
               if (sp_q != '0) begin
                  sp_d    = sp_q - SPW'(1);
                  bra     = 1'b1;
                  ret_sel = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
            if (is_illegal) err_d = 1'b1;
         end
         S_MEM: begin
            RD = is_load;
            WR = is_store;
            if (mem_ack) state_d = S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

   assign err       = err_q;
   assign sp        = sp_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_control_unit.sv
// Directed bench for seq_control_unit: inputs driven 1 ns after the rising
// edge, outputs sampled on the falling edge.
module tb_seq_control_unit;

   logic       clk;
   logic       rst;
   logic       instr_valid;
   logic       instr_ready;
   logic [5:0] opcode;
   logic [3:0] flags;
   logic [9:0] pc_in;
   logic       mem_ack;
   logic       immediate, alu_op, bra, ret_sel, RD, WR, halted, err;
   logic [9:0] ret_addr;
   logic [2:0] sp;
   logic [2:0] dbg_state;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   seq_control_unit #(.OPW(6), .FLAGW(4), .AW(10), .SDEPTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .opcode      (opcode),
      .flags       (flags),
      .pc_in       (pc_in),
      .mem_ack     (mem_ack),
      .immediate   (immediate),
      .alu_op      (alu_op),
      .bra         (bra),
      .ret_sel     (ret_sel),
      .RD          (RD),
      .WR          (WR),
      .halted      (halted),
      .err         (err),
      .ret_addr    (ret_addr),
      .sp          (sp),
      .dbg_state   (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      instr_valid = 1'b0;
      mem_ack     = 1'b0;
      opcode      = '0;
      flags       = '0;
      pc_in       = '0;
      rst         = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Offer one opcode in FETCH; returns 1 ns into the EXEC cycle.
   task automatic to_exec(input logic [5:0] op, input logic [3:0] fl, input logic [9:0] pc);
      instr_valid = 1'b1;
      opcode      = op;
      flags       = fl;
      pc_in       = pc;
      tick();
      instr_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      instr_valid = 1'b0;
      mem_ack = 1'b0;
      opcode = '0; flags = '0; pc_in = '0;
      #3;
      chk_cnt++;
      if ({RD, WR, bra, alu_op, immediate, ret_sel, halted, err} !== 8'b0 || sp !== 3'd0)
         $display("FAIL reset_outputs: got ctl=%b sp=%0d, want ctl=0 sp=0",
                  {RD, WR, bra, alu_op, immediate, ret_sel, halted, err}, sp);
      else pass_cnt++;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if (instr_ready !== 1'b1 || ret_addr !== 10'd0)
         $display("FAIL reset_ready: got ready=%b ret_addr=%h, want 1 and 000", instr_ready, ret_addr);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_alu_reg();
      instr_valid = 1'b1; opcode = 6'h05;
      @(negedge clk);
      chk_cnt++;
      if (instr_ready !== 1'b1 || alu_op !== 1'b0)
         $display("FAIL alu_c0: got ready=%b alu_op=%b, want 1 0", instr_ready, alu_op);
      else pass_cnt++;
      tick();
      instr_valid = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if (alu_op !== 1'b0 || instr_ready !== 1'b0)
         $display("FAIL alu_c1: got alu_op=%b ready=%b, want 0 0", alu_op, instr_ready);
      else pass_cnt++;
      tick();
      @(negedge clk);
      chk_cnt++;
      if (alu_op !== 1'b1 || immediate !== 1'b0)
         $display("FAIL alu_c2: got alu_op=%b imm=%b, want 1 0", alu_op, immediate);
      else pass_cnt++;
      tick();
      @(negedge clk);
      chk_cnt++;
      if (alu_op !== 1'b0 || instr_ready !== 1'b1)
         $display("FAIL alu_c3: got alu_op=%b ready=%b, want 0 1", alu_op, instr_ready);
      else pass_cnt++;
   endtask

   task automatic test_alu_imm();
      instr_valid = 1'b1; opcode = 6'h12;
      tick();
      instr_valid = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if (immediate !== 1'b1 || alu_op !== 1'b0)
         $display("FAIL imm_decode: got imm=%b alu_op=%b, want 1 0", immediate, alu_op);
      else pass_cnt++;
      tick();
      @(negedge clk);
      chk_cnt++;
      if (immediate !== 1'b1 || alu_op !== 1'b1)
         $display("FAIL imm_exec: got imm=%b alu_op=%b, want 1 1", immediate, alu_op);
      else pass_cnt++;
      tick();
      @(negedge clk);
      chk_cnt++;
      if (immediate !== 1'b0)
         $display("FAIL imm_fetch: got imm=%b, want 0", immediate);
      else pass_cnt++;
   endtask

   task automatic test_branch();
      logic [5:0] ops [5] = '{6'h31, 6'h31, 6'h30, 6'h33, 6'h32};
      logic [3:0] fls [5] = '{4'b1000, 4'b0111, 4'b0000, 4'b0010, 4'b1011};
      logic       exp [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         to_exec(ops[i], fls[i], 10'h0);
         @(negedge clk);
         chk_cnt++;
         if (bra !== exp[i] || ret_sel !== 1'b0)
            $display("FAIL branch_%0d: op=%h flags=%b got bra=%b ret_sel=%b, want %b 0",
                     i, ops[i], fls[i], bra, ret_sel, exp[i]);
         else pass_cnt++;
         tick();
         @(negedge clk);
         chk_cnt++;
         if (bra !== 1'b0 || instr_ready !== 1'b1)
            $display("FAIL branch_after_%0d: got bra=%b ready=%b, want 0 1", i, bra, instr_ready);
         else pass_cnt++;
      end
   endtask

   task automatic test_stack();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         to_exec(6'h35, 4'h0, 10'h010 + 10'(k));
         @(negedge clk);
         chk_cnt++;
         if (bra !== 1'b1)
            $display("FAIL call_%0d: got bra=%b, want 1", k, bra);
         else pass_cnt++;
         tick();
      end
      @(negedge clk);
      chk_cnt++;
      if (sp !== 3'd4 || err !== 1'b0 || ret_addr !== 10'h013)
         $display("FAIL stack_full: got sp=%0d err=%b ret_addr=%h, want 4 0 013", sp, err, ret_addr);
      else pass_cnt++;
      to_exec(6'h35, 4'h0, 10'h014);
      @(negedge clk);
      chk_cnt++;
      if (bra !== 1'b0)
         $display("FAIL call_overflow: got bra=%b, want 0", bra);
      else pass_cnt++;
      tick();
      @(negedge clk);
      chk_cnt++;
      if (err !== 1'b1 || sp !== 3'd4 || ret_addr !== 10'h013)
         $display("FAIL overflow_state: got err=%b sp=%0d ret_addr=%h, want 1 4 013", err, sp, ret_addr);
      else pass_cnt++;
      to_exec(6'h36, 4'h0, 10'h0);
      @(negedge clk);
      chk_cnt++;
      if (ret_addr !== 10'h013 || bra !== 1'b1 || ret_sel !== 1'b1)
         $display("FAIL ret_exec: got ret_addr=%h bra=%b ret_sel=%b, want 013 1 1", ret_addr, bra, ret_sel);
      else pass_cnt++;
      tick();
      @(negedge clk);
      chk_cnt++;
      if (sp !== 3'd3 || ret_addr !== 10'h012 || ret_sel !== 1'b0 || err !== 1'b1)
         $display("FAIL ret_after: got sp=%0d ret_addr=%h ret_sel=%b err=%b, want 3 012 0 1",
                  sp, ret_addr, ret_sel, err);
      else pass_cnt++;
   endtask

   task automatic test_ret_underflow();
      do_reset();
      to_exec(6'h36, 4'h0, 10'h0);
      @(negedge clk);
      chk_cnt++;
      if (bra !== 1'b0 || ret_sel !== 1'b0 || ret_addr !== 10'h000)
         $display("FAIL ret_empty: got bra=%b ret_sel=%b ret_addr=%h, want 0 0 000", bra, ret_sel, ret_addr);
      else pass_cnt++;
      tick();
      instr_valid = 1'b1; opcode = 6'h00;
      @(negedge clk);
      chk_cnt++;
      if (err !== 1'b1 || instr_ready !== 1'b1 || sp !== 3'd0)
         $display("FAIL ret_empty_after: got err=%b ready=%b sp=%0d, want 1 1 0", err, instr_ready, sp);
      else pass_cnt++;
      tick();
      instr_valid = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if (instr_ready !== 1'b0)
         $display("FAIL next_accepted: got ready=%b in decode, want 0", instr_ready);
      else pass_cnt++;
      tick();
      tick();
      @(negedge clk);
      chk_cnt++;
      if (err !== 1'b1 || instr_ready !== 1'b1)
         $display("FAIL err_sticky: got err=%b ready=%b, want 1 1", err, instr_ready);
      else pass_cnt++;
   endtask

   task automatic test_illegal();
      do_reset();
      to_exec(6'h22, 4'hF, 10'h0);
      @(negedge clk);
      chk_cnt++;
      if (alu_op !== 1'b0 || bra !== 1'b0 || RD !== 1'b0 || WR !== 1'b0)
         $display("FAIL illegal_exec: got alu=%b bra=%b rd=%b wr=%b, want 0 0 0 0", alu_op, bra, RD, WR);
      else pass_cnt++;
      tick();
      @(negedge clk);
      chk_cnt++;
      if (err !== 1'b1 || instr_ready !== 1'b1)
         $display("FAIL illegal_after: got err=%b ready=%b, want 1 1", err, instr_ready);
      else pass_cnt++;
   endtask

   task automatic test_mem();
      int rd_cycles;
      do_reset();
      // mem_ack while in FETCH must be ignored
      mem_ack = 1'b1;
      to_exec(6'h20, 4'h0, 10'h0);
      mem_ack = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if (RD !== 1'b0 || WR !== 1'b0)
         $display("FAIL load_exec: got rd=%b wr=%b, want 0 0", RD, WR);
      else pass_cnt++;
      tick();
      rd_cycles = 0;
      for (int c = 0; c < 4; c++) begin
         mem_ack = (c == 3);
         @(negedge clk);
         if (RD === 1'b1 && WR === 1'b0) rd_cycles++;
         tick();
      end
      mem_ack = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if (rd_cycles != 4 || RD !== 1'b0 || instr_ready !== 1'b1)
         $display("FAIL load_wait: got rd_cycles=%0d rd=%b ready=%b, want 4 0 1", rd_cycles, RD, instr_ready);
      else pass_cnt++;
      // STORE acknowledged in first MEM cycle: back in FETCH 4 cycles after acceptance
      to_exec(6'h21, 4'h0, 10'h0);
      tick();
      mem_ack = 1'b1;
      @(negedge clk);
      chk_cnt++;
      if (WR !== 1'b1 || RD !== 1'b0)
         $display("FAIL store_mem: got wr=%b rd=%b, want 1 0", WR, RD);
      else pass_cnt++;
      tick();
      mem_ack = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if (WR !== 1'b0 || instr_ready !== 1'b1)
         $display("FAIL store_done: got wr=%b ready=%b, want 0 1", WR, instr_ready);
      else pass_cnt++;
   endtask

   task automatic test_rst_mid_mem();
      do_reset();
      to_exec(6'h35, 4'h0, 10'h055);
      tick();
      to_exec(6'h20, 4'h0, 10'h0);
      tick();
      @(negedge clk);
      chk_cnt++;
      if (RD !== 1'b1 || sp !== 3'd1 || ret_addr !== 10'h055)
         $display("FAIL mem_before_rst: got rd=%b sp=%0d ret_addr=%h, want 1 1 055", RD, sp, ret_addr);
      else pass_cnt++;
      #2;
      rst = 1'b1;
      #1;
      chk_cnt++;
      if (RD !== 1'b0 || sp !== 3'd0 || ret_addr !== 10'h000)
         $display("FAIL async_rst: got rd=%b sp=%0d ret_addr=%h, want 0 0 000", RD, sp, ret_addr);
      else pass_cnt++;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if (instr_ready !== 1'b1 || RD !== 1'b0)
         $display("FAIL rst_release: got ready=%b rd=%b, want 1 0", instr_ready, RD);
      else pass_cnt++;
   endtask

   task automatic test_halt();
      do_reset();
      to_exec(6'h3F, 4'h0, 10'h0);
      @(negedge clk);
      chk_cnt++;
      if (halted !== 1'b0 || err !== 1'b0)
         $display("FAIL halt_exec: got halted=%b err=%b, want 0 0", halted, err);
      else pass_cnt++;
      tick();
      instr_valid = 1'b1; opcode = 6'h05;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk_cnt++;
         if (halted !== 1'b1 || instr_ready !== 1'b0 || alu_op !== 1'b0)
            $display("FAIL halt_hold_%0d: got halted=%b ready=%b alu=%b, want 1 0 0",
                     c, halted, instr_ready, alu_op);
         else pass_cnt++;
         tick();
      end
      do_reset();
      @(negedge clk);
      chk_cnt++;
      if (halted !== 1'b0 || instr_ready !== 1'b1)
         $display("FAIL halt_reset: got halted=%b ready=%b, want 0 1", halted, instr_ready);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_alu_reg();
      tick();
      test_alu_imm();
      tick();
      test_branch();
      test_stack();
      test_ret_underflow();
      test_illegal();
      test_mem();
      test_rst_mid_mem();
      test_halt();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
